// File: rtl/exe_wb_stage.sv
// exe_wb_stage
// ------------
// Write-back stage and bypass network of a 3-stage register-file datapath.
// It captures the EXE result in an EXE/WB pipeline register and drives the
// register-file write port from that register one cycle later. It also
// forwards the freshest value of each ID-stage source operand, and it counts
// committed instructions and committed register writes.
//
// Ports
//   clk                   clock, rising edge
//   rst                   asynchronous active-low reset
//   stall                 hold the EXE/WB register and the counters
//   flush                 load a bubble instead of the EXE result
//   valid_in              EXE stage holds a real instruction
//   wen_in                EXE instruction writes a register
//   waddr_in              EXE destination register
//   aluout                EXE result
//   raddr1, raddr2        ID-stage source addresses
//   rdata1_in, rdata2_in  raw register-file read data
//   wb_wen                register-file write enable (registered)
//   wb_waddr              register-file write address (registered)
//   wb_wdata              register-file write data (registered)
//   fwd_rdata1/2          bypassed operands
//   retire_count          instructions committed (wraps)
//   write_count           register writes committed (wraps)
module exe_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              wen_in,
  input  logic [ADDR_W-1:0] waddr_in,
  input  logic [DATA_W-1:0] aluout,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata1_in,
  input  logic [DATA_W-1:0] rdata2_in,
  output logic              wb_wen,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] fwd_rdata1,
  output logic [DATA_W-1:0] fwd_rdata2,
  output logic [CNT_W-1:0]  retire_count,
  output logic [CNT_W-1:0]  write_count
);

  // EXE/WB pipeline register
  logic              wb_valid_q, wb_valid_d;
  logic              wb_wen_q,   wb_wen_d;
  logic [ADDR_W-1:0] wb_waddr_q, wb_waddr_d;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;

  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [CNT_W-1:0]  write_q,  write_d;

  // The entry in WB commits whenever it leaves the register: on a normal
  // (unstalled) edge, or on a flush edge even while stalled, because the
  // flush replaces it with a bubble and it would otherwise be lost.
  logic commit;
  assign commit = wb_valid_q & (flush | ~stall);

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_wen_d   = wb_wen_q;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
    if (flush) begin
      wb_valid_d = 1'b0;
      wb_wen_d   = 1'b0;
      wb_waddr_d = '0;
      wb_wdata_d = '0;
    end else if (!stall) begin
      wb_valid_d = valid_in;
      // Register 0 is hard-wired to zero, so writes to it are suppressed.
      wb_wen_d   = valid_in & wen_in & (waddr_in != '0);
      wb_waddr_d = waddr_in;
      wb_wdata_d = aluout;
    end
  end

  always_comb begin
    retire_d = retire_q;
    write_d  = write_q;
    if (commit) begin
      retire_d = retire_q + 1'b1;
      if (wb_wen_q) write_d = write_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      retire_q   <= '0;
      write_q    <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_wen_q   <= wb_wen_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
      retire_q   <= retire_d;
      write_q    <= write_d;
    end
  end

  assign wb_wen       = wb_wen_q;
  assign wb_waddr     = wb_waddr_q;
  assign wb_wdata     = wb_wdata_q;
  assign retire_count = retire_q;
  assign write_count  = write_q;

  // Bypass network. The EXE producer is younger than the WB entry, so it is
  // checked first. The WB match also covers the register-file
  // read-during-write cycle.
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic [DATA_W-1:0] fwd   [2];

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;
  assign rdata[0] = rdata1_in;
  assign rdata[1] = rdata2_in;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
    always_comb begin
      fwd[gi] = rdata[gi];
      if (raddr[gi] == '0)
        fwd[gi] = '0;
      else if (valid_in && wen_in && (waddr_in == raddr[gi]))
        fwd[gi] = aluout;
      else if (wb_wen_q && (wb_waddr_q == raddr[gi]))
        fwd[gi] = wb_wdata_q;
    end
  end

  assign fwd_rdata1 = fwd[0];
  assign fwd_rdata2 = fwd[1];

endmodule

// File: tb/tb_exe_wb_stage.sv
module tb_exe_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, valid_in, wen_in;
  logic [4:0]  waddr_in, raddr1, raddr2;
  logic [31:0] aluout, rdata1_in, rdata2_in;

  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata, fwd_rdata1, fwd_rdata2, retire_count, write_count;

  // Narrow-counter instance sharing the same stimulus, used for wrap checks.
  logic        s_wb_wen;
  logic [4:0]  s_wb_waddr;
  logic [31:0] s_wb_wdata, s_fwd1, s_fwd2;
  logic [3:0]  s_retire, s_write;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_in(valid_in), .wen_in(wen_in), .waddr_in(waddr_in), .aluout(aluout),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .fwd_rdata1(fwd_rdata1), .fwd_rdata2(fwd_rdata2),
    .retire_count(retire_count), .write_count(write_count)
  );

  exe_wb_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_in(valid_in), .wen_in(wen_in), .waddr_in(waddr_in), .aluout(aluout),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in),
    .wb_wen(s_wb_wen), .wb_waddr(s_wb_waddr), .wb_wdata(s_wb_wdata),
    .fwd_rdata1(s_fwd1), .fwd_rdata2(s_fwd2),
    .retire_count(s_retire), .write_count(s_write)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exe(input logic v, input logic [4:0] a, input logic [31:0] d);
    valid_in = v;
    wen_in   = 1'b1;
    waddr_in = a;
    aluout   = d;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    valid_in = 1'b0; wen_in = 1'b0; waddr_in = '0; aluout = '0;
    raddr1 = '0; raddr2 = '0; rdata1_in = 32'hDEAD_0001; rdata2_in = 32'hBEEF_0002;
    #1;
    check("reset_wen", wb_wen, 0);
    check("reset_retire", retire_count, 0);
    #20 rst = 1'b1;                       // released mid-cycle (t=21)

    // Basic write-back
    exe(1'b1, 5'd5, 32'h0000_00AA);
    step();
    check("basic_wen", wb_wen, 1);
    check("basic_waddr", wb_waddr, 5);
    check("basic_wdata", wb_wdata, 32'hAA);
    check("basic_retire_lat", retire_count, 0);
    exe(1'b0, 5'd0, 32'h0);
    step();
    check("basic_retire", retire_count, 1);
    check("basic_write", write_count, 1);

    // Bypass priority
    exe(1'b1, 5'd7, 32'h11);
    step();                                // WB: r7=0x11, retire still 1
    exe(1'b1, 5'd7, 32'h22);
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    check("byp_exe_p1", fwd_rdata1, 32'h22);
    check("byp_exe_p2", fwd_rdata2, 32'h22);
    valid_in = 1'b0;
    #1;
    check("byp_wb_p1", fwd_rdata1, 32'h11);
    check("byp_wb_p2", fwd_rdata2, 32'h11);
    raddr2 = 5'd9;
    #1;
    check("byp_nomatch_p2", fwd_rdata2, 32'hBEEF_0002);
    raddr2 = 5'd7;
    raddr1 = 5'd0;
    exe(1'b1, 5'd0, 32'h33);
    #1;
    check("byp_r0_p1", fwd_rdata1, 0);
    check("byp_r0write_p2", fwd_rdata2, 32'h11);

    // Register-0 write
    aluout = 32'hFFFF_FFFF;
    step();                                // r7 commits: retire 2, write 2
    check("r0_wen", wb_wen, 0);
    check("r0_wdata", wb_wdata, 32'hFFFF_FFFF);
    check("r0_retire_r7", retire_count, 2);
    check("r0_write_r7", write_count, 2);
    exe(1'b0, 5'd0, 32'h0);
    step();
    check("r0_retire", retire_count, 3);
    check("r0_write", write_count, 2);

    // Stall for three edges
    exe(1'b1, 5'd4, 32'h44);
    step();                                // WB: r4
    exe(1'b1, 5'd9, 32'h99);
    stall = 1'b1;
    raddr1 = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_waddr", wb_waddr, 4);
      check("stall_wdata", wb_wdata, 32'h44);
      check("stall_retire", retire_count, 3);
    end
    check("stall_bypass_exe", fwd_rdata1, 32'h99);
    stall = 1'b0;
    valid_in = 1'b0;
    step();
    check("stall_rel_retire", retire_count, 4);
    check("stall_rel_write", write_count, 3);
    check("stall_rel_wen", wb_wen, 0);

    // Stall and flush together
    exe(1'b1, 5'd6, 32'h66);
    step();                                // WB: r6
    exe(1'b1, 5'd8, 32'h88);
    stall = 1'b1; flush = 1'b1;
    step();
    check("sf_retire", retire_count, 5);
    check("sf_write", write_count, 4);
    check("sf_wen", wb_wen, 0);
    check("sf_waddr", wb_waddr, 0);
    check("sf_wdata", wb_wdata, 0);
    stall = 1'b0; flush = 1'b0;
    valid_in = 1'b0;
    step();
    check("sf_once_retire", retire_count, 5);
    check("sf_once_write", write_count, 4);

    // Asynchronous reset mid-cycle with wb_wen=1
    exe(1'b1, 5'd3, 32'h1234);
    step();
    check("pre_rst_wen", wb_wen, 1);
    valid_in = 1'b0;
    raddr1 = 5'd3;
    rdata1_in = 32'hCAFE_0003;
    #2 rst = 1'b0;
    #1;
    check("arst_wen", wb_wen, 0);
    check("arst_waddr", wb_waddr, 0);
    check("arst_wdata", wb_wdata, 0);
    check("arst_retire", retire_count, 0);
    check("arst_write", write_count, 0);
    check("arst_s_retire", s_retire, 0);
    check("arst_fwd1", fwd_rdata1, 32'hCAFE_0003);
    #1 rst = 1'b1;

    // Counter wrap: 17 committed writes
    for (int i = 0; i < 17; i++) begin
      exe(1'b1, 5'(1 + (i % 31)), 32'(i));
      step();
    end
    valid_in = 1'b0;
    step();
    check("wrap_retire", retire_count, 17);
    check("wrap_write", write_count, 17);
    check("wrap_s_retire", s_retire, 1);
    check("wrap_s_write", s_write, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: observed no finish, required finish before 20000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exe_wb_stage.md
# exe_wb_stage

Write-back stage and bypass network for the 3-stage pipelined register-file datapath: consumes the EXE-stage result (ALU output plus destination address), registers it in an EXE/WB pipeline register, and drives the register-file write port one cycle later. It also supplies bypassed operands to the ID stage, so an instruction reading a register being produced in EXE or WB gets the fresh value. It keeps commit and write counters for bench and debug visibility.

## Interface
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width (register 0 hard-wired to zero)
- CNT_W, 32, width of both counters

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- stall  input  1  hold EXE/WB register and counters
- flush  input  1  load a bubble instead of the EXE result
- valid_in  input  1  EXE stage holds a real instruction
- wen_in  input  1  EXE instruction writes a register
- waddr_in  input  ADDR_W  EXE destination register
- aluout  input  DATA_W  EXE result
- raddr1, raddr2  input  ADDR_W  ID-stage source addresses
- rdata1_in, rdata2_in  input  DATA_W  raw register-file read data
- wb_wen  output  1  register-file write enable
- wb_waddr  output  ADDR_W  register-file write address
- wb_wdata  output  DATA_W  register-file write data
- fwd_rdata1, fwd_rdata2  output  DATA_W  bypassed operands to ID/EXE register
- retire_count  output  CNT_W  instructions committed
- write_count  output  CNT_W  register writes committed

## Operation
- EXE/WB register fields: wb_valid, wb_wen, wb_waddr, wb_wdata; wb_wen/wb_waddr/wb_wdata are driven directly from it (no combinational path from inputs).
- Per rising edge, priority rst > flush > stall > load:
  - flush: wb_valid=0, wb_wen=0, wb_waddr=0, wb_wdata=0 (applies even if stall=1).
  - stall: all fields hold.
  - load: wb_valid<=valid_in; wb_wen<=valid_in & wen_in & (waddr_in!=0); wb_waddr<=waddr_in; wb_wdata<=aluout.
- Writes to register 0 never assert wb_wen, but still count as a retire.
- Commit: on each rising edge with rst high, wb_valid=1 and stall=0, retire_count+=1; additionally write_count+=1 if wb_wen=1. The entry already in WB commits on a flush edge (flush only kills the incoming EXE instruction). Stalled entries commit exactly once. Counters wrap modulo 2^CNT_W.
- Bypass, per port k (combinational, independent of stall/flush):
  - raddrk==0 -> 0
  - else valid_in & wen_in & waddr_in==raddrk -> aluout (younger producer wins)
  - else wb_wen & wb_waddr==raddrk -> wb_wdata
  - else rdata_k_in
- Register file writes on the rising edge while wb_wen=1; the bypass covers the read-during-write cycle.

## Timing
- Reset (rst=0, asynchronous): all EXE/WB fields, wb_wen, wb_waddr, wb_wdata, retire_count, write_count = 0 immediately, without waiting for clk. fwd_rdata* reflect inputs only.
- Deassertion of rst takes effect at the next rising edge; first load possible on that edge.
- Latency: valid_in/aluout at edge N -> wb_* valid after edge N; counted at edge N+1.
- Bypass: zero-cycle combinational.
- Throughput: one instruction per cycle when stall=0.
- Back-to-back producers to the same register: EXE match wins over WB match.
- Reset mid-stall or mid-flush: reset wins; pipeline register empty; counters cleared.

## Test plan
- Reset: drive rst=0 asynchronously mid-cycle with wb_wen=1 -> wb_wen, wb_waddr, wb_wdata, both counters 0 before next edge; fwd_rdata1 = rdata1_in when raddr1=3, no match.
- Basic write-back: valid_in=1, wen_in=1, waddr_in=5, aluout=0x0000_00AA at edge 1 -> wb_wen=1, wb_waddr=5, wb_wdata=0xAA after edge 1; retire_count=1, write_count=1 after edge 2.
- Bypass priority: WB holds r7=0x11; EXE presents r7=0x22; raddr1=7, raddr2=7 -> fwd_rdata1=fwd_rdata2=0x22; drop valid_in -> both 0x11; raddr1=0 with EXE writing r0=0x33 -> fwd_rdata1=0.
- Register-0 write: valid_in=1, wen_in=1, waddr_in=0, aluout=0xFFFF_FFFF -> wb_wen=0; next edge retire_count+1, write_count unchanged.
- Stall/flush: stall=1 for 3 edges with WB r4=0x44 -> wb_* held, retire_count +1 total after release; stall=1 and flush=1 together -> WB entry commits once, wb_valid=0, wb_wen=0 next.
- Counter wrap: CNT_W=4, commit 17 valid writes -> retire_count=1, write_count=1.
